// File: rtl/op_seq_pkg.sv
// op_seq_pkg: shared state encoding, instruction classes and field positions for op_sequencer
package op_seq_pkg;
  localparam int INSTR_W = 16;
  localparam int CLS_HI = 15;
  localparam int CLS_LO = 12;
  localparam int OP_HI = 11;
  localparam int OP_LO = 8;
  localparam int ARG_HI = 7;
  localparam int ARG_LO = 0;
  localparam logic [3:0] CLS_NOP = 4'h0;
  localparam logic [3:0] CLS_ALUI = 4'h1;
  localparam logic [3:0] CLS_ALUM = 4'h2;
  localparam logic [3:0] CLS_ST = 4'h3;
  localparam logic [3:0] CLS_JMP = 4'h4;
  localparam logic [3:0] CLS_JZ = 4'h5;
  localparam logic [3:0] CLS_JC = 4'h6;
  localparam logic [3:0] CLS_HALT = 4'hF;
  typedef enum logic [2:0] {FETCH, DECODE, MEM_RD, MEM_WR, EXEC, HALT, TRAP} state_t;
endpackage

// File: rtl/op_sequencer_pc_unit.sv
// op_sequencer_pc_unit: program counter with increment, branch load and natural wrap
// Ports: clk, rst_n (async, active low), inc (advance after fetch), load/target (branch), pc (current address)
module op_sequencer_pc_unit #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            load,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= '0;
    else if (load) pc <= target;
    else if (inc) pc <= pc + PC_W'(1);
endmodule

// File: rtl/op_sequencer.sv
// op_sequencer: fetch/decode/execute controller driving the ALU + accumulator + carry block
// Ports: prog_* instruction fetch handshake, dmem_* data memory handshake, acc_in/carry_in
// datapath status, alu_op/alu_b/aku_enable datapath control, halted stop status.
// Build option OP_SEQ_TRAP_EN: illegal classes enter TRAP and raise the extra trap output.
module op_sequencer
  import op_seq_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int DATA_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               prog_req,
  output logic [PC_W-1:0]    prog_addr,
  input  logic               prog_ack,
  input  logic [INSTR_W-1:0] prog_data,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [7:0]         dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  acc_in,
  input  logic               carry_in,
  output logic [3:0]         alu_op,
  output logic [DATA_W-1:0]  alu_b,
  output logic               aku_enable,
  output logic               halted
`ifdef OP_SEQ_TRAP_EN
  ,
  output logic               trap
`endif
);
  state_t state;
  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0] b_reg;
  logic [3:0] cls;
  logic [7:0] arg;
  logic pc_inc, pc_load;
  assign cls = ir[CLS_HI:CLS_LO];
  assign arg = ir[ARG_HI:ARG_LO];
  assign alu_op = ir[OP_HI:OP_LO];
  assign alu_b = b_reg;
  assign dmem_addr = arg;
  // store data only shows on the bus while a write is in flight
  assign dmem_wdata = dmem_we ? acc_in : '0;
  // prog_req guards the ack so stray or post-reset acks never advance the PC
  assign pc_inc = state == FETCH && prog_req && prog_ack;
  assign pc_load = state == DECODE && (cls == CLS_JMP || (cls == CLS_JZ && acc_in == '0) || (cls == CLS_JC && carry_in));
  op_sequencer_pc_unit #(.PC_W(PC_W)) u_pc (
    .clk(clk),
    .rst_n(rst_n),
    .inc(pc_inc),
    .load(pc_load),
    .target(PC_W'(arg)),
    .pc(prog_addr)
  );
  // request strobes are set on entry to their state so they are clean register outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FETCH;
      ir <= '0;
      b_reg <= '0;
      prog_req <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      aku_enable <= 1'b0;
      halted <= 1'b0;
`ifdef OP_SEQ_TRAP_EN
      trap <= 1'b0;
`endif
    end else begin
      aku_enable <= 1'b0;
      case (state)
        FETCH:
          if (!prog_req) prog_req <= 1'b1;
          else if (prog_ack) begin
            prog_req <= 1'b0;
            ir <= prog_data;
            state <= DECODE;
          end
        DECODE:
          case (cls)
            CLS_ALUI: begin
              b_reg <= DATA_W'(arg);
              aku_enable <= 1'b1;
              state <= EXEC;
            end
            CLS_ALUM: begin
              dmem_req <= 1'b1;
              state <= MEM_RD;
            end
            CLS_ST: begin
              dmem_req <= 1'b1;
              dmem_we <= 1'b1;
              state <= MEM_WR;
            end
            CLS_HALT: begin
              halted <= 1'b1;
              state <= HALT;
            end
            CLS_NOP, CLS_JMP, CLS_JZ, CLS_JC: begin
              prog_req <= 1'b1;
              state <= FETCH;
            end
            default: begin
`ifdef OP_SEQ_TRAP_EN
              trap <= 1'b1;
              halted <= 1'b1;
              state <= TRAP;
`else
              prog_req <= 1'b1;
              state <= FETCH;
`endif
            end
          endcase
        MEM_RD:
          if (dmem_ack) begin
            b_reg <= dmem_rdata;
            dmem_req <= 1'b0;
            aku_enable <= 1'b1;
            state <= EXEC;
          end
        MEM_WR:
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we <= 1'b0;
            prog_req <= 1'b1;
            state <= FETCH;
          end
        EXEC: begin
          prog_req <= 1'b1;
          state <= FETCH;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_op_sequencer.sv
// tb_op_sequencer: scoreboard bench with an instruction-level reference model of op_sequencer
module tb_op_sequencer;
  localparam logic [3:0] EV_F = 4'h1, EV_R = 4'h2, EV_W = 4'h3, EV_X = 4'h4;
  logic clk = 0, rst_n = 1;
  logic prog_req, prog_ack, dmem_req, dmem_we, dmem_ack, aku_enable, halted, carry;
  logic [7:0] prog_addr, dmem_addr, dmem_wdata, dmem_rdata, alu_b, acc;
  logic [15:0] prog_data;
  logic [3:0] alu_op;
`ifdef OP_SEQ_TRAP_EN
  logic trap;
`endif
  logic [15:0] prog [256];
  logic [7:0] dmem [256];
  logic [19:0] expq [$];
  int total = 0, bad = 0, aku_cnt = 0, dreq_cnt = 0;
  int pcnt = 0, plim = 0, dcnt = 0, dlim = 0, ddly_fix = 0;
  bit chk_en = 0, tied = 0, p_rand = 0, d_rand = 0, d_manual = 0, p_hold = 0;
  bit m_halt, m_trap;
  logic [7:0] m_acc;
  always #5 clk = ~clk;
  op_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .prog_req(prog_req), .prog_addr(prog_addr), .prog_ack(prog_ack), .prog_data(prog_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .acc_in(acc), .carry_in(carry),
    .alu_op(alu_op), .alu_b(alu_b), .aku_enable(aku_enable), .halted(halted)
`ifdef OP_SEQ_TRAP_EN
    , .trap(trap)
`endif
  );
  // operation block stand-in: {carry, result}
  function automatic logic [8:0] alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic c);
    case (op)
      4'd0: return {1'b0, a} + {1'b0, b};
      4'd1: return {1'b0, a} - {1'b0, b};
      4'd2: return {c, a & b};
      4'd3: return {c, a | b};
      4'd4: return {c, a ^ b};
      default: return {c, b};
    endcase
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) {carry, acc} <= 9'h0;
    else if (aku_enable) {carry, acc} <= alu(alu_op, acc, alu_b, carry);
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic got(input string nm, input logic [19:0] ev);
    logic [19:0] e;
    total++;
    if (expq.size() == 0) begin
      bad++;
      $display("FAIL %s: got unexpected event %h expected none", nm, ev);
    end else begin
      e = expq.pop_front();
      if (e !== ev) begin
        bad++;
        $display("FAIL %s: got %h expected %h", nm, ev, e);
      end
    end
  endtask
  // program memory responder
  initial begin
    prog_ack = 0;
    prog_data = 0;
    forever begin
      @(posedge clk); #1;
      prog_data = prog[prog_addr];
      if (p_hold) prog_ack = 0;
      else if (tied) prog_ack = 1;
      else if (prog_req) begin
        if (pcnt >= plim) begin
          prog_ack = 1;
          pcnt = 0;
          plim = p_rand ? $urandom_range(0, 3) : 0;
        end else begin
          prog_ack = 0;
          pcnt++;
        end
      end else prog_ack = 0;
    end
  end
  // data memory responder
  initial begin
    dmem_ack = 0;
    dmem_rdata = 0;
    forever begin
      @(posedge clk); #1;
      if (!d_manual) begin
        if (dmem_req) begin
          if (dcnt >= dlim) begin
            dmem_ack = 1;
            if (dmem_we) dmem[dmem_addr] = dmem_wdata;
            else dmem_rdata = dmem[dmem_addr];
            dcnt = 0;
            dlim = d_rand ? $urandom_range(0, 4) : ddly_fix;
          end else begin
            dmem_ack = 0;
            dcnt++;
          end
        end else dmem_ack = 0;
      end
    end
  end
  // monitor: every DUT transaction is matched against the model's expected stream
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("req_excl", {63'h0, prog_req & dmem_req}, 64'h0);
      if (prog_req && prog_ack) got("fetch", {EV_F, prog_addr, 8'h0});
      if (dmem_req && dmem_ack) got("dmem", dmem_we ? {EV_W, dmem_addr, dmem_wdata} : {EV_R, dmem_addr, 8'h0});
      if (aku_enable) begin
        aku_cnt++;
        got("exec", {EV_X, 4'h0, alu_op, alu_b});
      end
      if (dmem_req) dreq_cnt++;
    end
  end
  // instruction-level interpreter producing the expected transaction stream
  task automatic build(input int steps);
    logic [7:0] pc = 0, a = 0, x, b;
    logic c = 0;
    logic [15:0] w;
    logic [7:0] dm [256];
    for (int i = 0; i < 256; i++) dm[i] = dmem[i];
    expq.delete();
    m_halt = 0;
    m_trap = 0;
    for (int s = 0; s < steps && !m_halt; s++) begin
      w = prog[pc];
      expq.push_back({EV_F, pc, 8'h0});
      pc++;
      x = w[7:0];
      case (w[15:12])
        4'h0: ;
        4'h1, 4'h2: begin
          b = w[15:12] == 4'h1 ? x : dm[x];
          if (w[15:12] == 4'h2) expq.push_back({EV_R, x, 8'h0});
          expq.push_back({EV_X, 4'h0, w[11:8], b});
          {c, a} = alu(w[11:8], a, b, c);
        end
        4'h3: begin
          expq.push_back({EV_W, x, a});
          dm[x] = a;
        end
        4'h4: pc = x;
        4'h5: if (a == 0) pc = x;
        4'h6: if (c) pc = x;
        4'hF: m_halt = 1;
        default: begin
`ifdef OP_SEQ_TRAP_EN
          m_halt = 1;
          m_trap = 1;
`endif
        end
      endcase
    end
    m_acc = a;
  endtask
  task automatic run(input string nm, input int steps, input bit t, input bit rnd, input int dfix);
    int n = 0;
    rst_n = 0;
    #1;
    check({nm, ":reset"}, {23'h0, prog_req, prog_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata, alu_op, alu_b, aku_enable, halted}, 64'h0);
    tied = t;
    p_rand = rnd;
    d_rand = rnd;
    ddly_fix = dfix;
    dlim = dfix;
    dcnt = 0;
    plim = 0;
    pcnt = 0;
    build(steps);
    aku_cnt = 0;
    dreq_cnt = 0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    rst_n = 1;
    while (expq.size() != 0 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    chk_en = 0;
    check({nm, ":drain"}, 64'(expq.size()), 64'h0);
    if (m_halt) begin
      repeat (4) @(negedge clk);
      check({nm, ":halted"}, {62'h0, halted, prog_req}, {62'h0, 2'b10});
      check({nm, ":acc"}, 64'(acc), 64'(m_acc));
`ifdef OP_SEQ_TRAP_EN
      check({nm, ":trap"}, 64'(trap), 64'(m_trap));
`endif
    end
  endtask
  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 16'h0;
  endtask
  initial begin
    int n;
    logic [3:0] cl;
    for (int i = 0; i < 256; i++) dmem[i] = 8'h0;
    #3;
    clear_prog();
    prog[0] = 16'h1005;
    prog[1] = 16'h1003;
    prog[2] = 16'hF000;
    run("alui", 10, 1, 0, 0);
    check("alui:acc8", 64'(acc), 64'h08);
    check("alui:pulses", 64'(aku_cnt), 64'd2);
    clear_prog();
    prog[0] = 16'h2010;
    prog[1] = 16'hF000;
    dmem[8'h10] = 8'h7F;
    run("alum", 10, 0, 0, 2);
    check("alum:req_cycles", 64'(dreq_cnt), 64'd3);
    check("alum:pulses", 64'(aku_cnt), 64'd1);
    clear_prog();
    prog[0] = 16'h5020;
    prog[8'h20] = 16'h1001;
    prog[8'h21] = 16'h5040;
    prog[8'h22] = 16'hF000;
    run("jz", 10, 0, 0, 0);
    clear_prog();
    run("wrap", 258, 0, 0, 0);
    clear_prog();
    prog[0] = 16'h1003;
    prog[1] = 16'h9055;
    prog[2] = 16'hF000;
    run("illegal", 10, 0, 0, 0);
    clear_prog();
    prog[0] = 16'h1033;
    prog[1] = 16'h3040;
    rst_n = 0;
    #1;
    tied = 0;
    p_rand = 0;
    plim = 0;
    pcnt = 0;
    d_manual = 1;
    dmem_ack = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    n = 0;
    while (!(dmem_req && dmem_we) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("st:req", {46'h0, dmem_req, dmem_we, dmem_addr, dmem_wdata}, {46'h0, 2'b11, 8'h40, 8'h33});
    #2 rst_n = 0;
    #1 check("st:async_reset", {51'h0, prog_req, dmem_req, dmem_we, aku_enable, halted, prog_addr}, 64'h0);
    p_hold = 1;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1 dmem_ack = 1;
    @(posedge clk); #1 dmem_ack = 0;
    @(negedge clk);
    check("st:late_ack", {62'h0, dmem_req, dmem_we}, 64'h0);
    p_hold = 0;
    n = 0;
    while (!(prog_req && prog_ack) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("st:resume", {55'h0, prog_req && prog_ack, prog_addr}, {55'h0, 1'b1, 8'h00});
    d_manual = 0;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 256; i++) begin
        n = $urandom_range(0, 39);
        cl = n < 2 ? 4'h0 : n < 8 ? 4'h1 : n < 13 ? 4'h2 : n < 17 ? 4'h3 : n < 19 ? 4'h4 :
             n < 25 ? 4'h5 : n < 31 ? 4'h6 : n < 33 ? 4'(7 + $urandom_range(0, 7)) : n < 39 ? 4'h0 : 4'hF;
        prog[i] = {cl, 4'($urandom_range(0, 7)), (cl == 4'h2 || cl == 4'h3) ? 8'($urandom_range(0, 15)) : 8'($urandom)};
        dmem[i] = 8'($urandom);
      end
      run("rand", 150, 0, 1, 1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
